// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 5..DATA_W_MAX data bits LSB-first, optional parity, 1 or 2 stop bits.
// Optional line-break feature (break_i) is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_framer #(
  parameter int DATA_W_MAX = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_en_i,
  input  logic                  tick_i,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_i,
`endif
  input  logic [DATA_W_MAX-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic [3:0]            data_bits_i,
  input  logic [2:0]            parity_mode_i,
  input  logic                  stop_bits_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  tx_finish_o
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic                  ready_q, ready_d;
  logic                  tx_q, tx_d;
  logic [DATA_W_MAX-1:0] shift_q, shift_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;

  logic brk;
  logic accept;
  logic counting;
  logic bit_end;
  logic [3:0] nbits_in;

`ifdef UART_TX_BREAK_EN
  assign brk = break_i;
`else
  assign brk = 1'b0;
`endif

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5) return 4'd5;
    if (b > 4'(DATA_W_MAX)) return 4'(DATA_W_MAX);
    return b;
  endfunction

  // Only the active data bits take part; upper bits of a short character are ignored.
  function automatic logic calc_parity(input logic [DATA_W_MAX-1:0] d,
                                       input logic [3:0] nbits,
                                       input logic [2:0] mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (i < int'(nbits)) x = x ^ d[i];
    end
    case (mode)
      3'd1:    return x;
      3'd2:    return ~x;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign data_ready_o = ready_q & tx_en_i & ~brk;
  assign accept       = data_valid_i & data_ready_o;
  assign counting     = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
  assign bit_end      = counting & tick_i & (tick_q == TICK_LAST);
  assign nbits_in     = clamp_bits(data_bits_i);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    ready_d   = (state_q == S_IDLE) & ~accept & ~brk;
    tx_d      = 1'b1;

    if (counting && tick_i) tick_d = bit_end ? '0 : tick_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = data_i;
          nbits_d   = nbits_in;
          par_en_d  = (parity_mode_i >= 3'd1) && (parity_mode_i <= 3'd4);
          par_bit_d = calc_parity(data_i, nbits_in, parity_mode_i);
          stop2_d   = stop_bits_i;
          tick_d    = '0;
          bit_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == nbits_q - 4'd1) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Second stop bit reuses the bit counter as a one-bit extension.
        if (bit_end) begin
          if (stop2_q && (bit_q == 4'd0)) bit_d = 4'd1;
          else state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so tx_o changes with the state.
    case (state_d)
      S_IDLE:   tx_d = ~brk;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      ready_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    nbits_q   <= nbits_d;
    par_en_q  <= par_en_d;
    par_bit_q <= par_bit_d;
    stop2_q   <= stop2_d;
  end

  assign tx_o        = tx_q;
  assign busy_o      = (state_q != S_IDLE) | brk;
  assign tx_finish_o = (state_q == S_FINISH);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame shape, parity modes, timing, back-to-back, enable drop, reset.
`timescale 1ns/1ps
module tb_uart_tx_framer;
  localparam int DW = 9;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tx_en_i;
  logic          tick_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic [3:0]    data_bits_i;
  logic [2:0]    parity_mode_i;
  logic          stop_bits_i;
  logic          tx_o;
  logic          busy_o;
  logic          tx_finish_o;
`ifdef UART_TX_BREAK_EN
  logic          break_i;
`endif

  int checks = 0;
  int errors = 0;
  int tick_div = 1;
  logic exp_bits [0:15];
  logic obs_bits [0:15];
  int   exp_n;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_W_MAX(DW), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_en_i       (tx_en_i),
    .tick_i        (tick_i),
`ifdef UART_TX_BREAK_EN
    .break_i       (break_i),
`endif
    .data_i        (data_i),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .data_bits_i   (data_bits_i),
    .parity_mode_i (parity_mode_i),
    .stop_bits_i   (stop_bits_i),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .tx_finish_o   (tx_finish_o)
  );

  initial begin : tick_gen
    int ph;
    ph = 0;
    tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div <= 1) tick_i = 1'b1;
      else begin
        tick_i = (ph == 0);
        ph = (ph + 1) % tick_div;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected line levels, one entry per bit period; par < 0 means no parity bit.
  task automatic build_exp(input logic [DW-1:0] d, input int nb, input int par, input int nstop);
    logic [DW-1:0] dv;
    dv = d;
    exp_n = 0;
    exp_bits[exp_n] = 1'b0; exp_n++;
    for (int i = 0; i < nb; i++) begin exp_bits[exp_n] = dv[i]; exp_n++; end
    if (par >= 0) begin exp_bits[exp_n] = (par != 0); exp_n++; end
    for (int i = 0; i < nstop; i++) begin exp_bits[exp_n] = 1'b1; exp_n++; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [3:0] nb, input logic [2:0] pm,
                      input logic sb, output bit ok);
    int n;
    data_i = d; data_bits_i = nb; parity_mode_i = pm; stop_bits_i = sb;
    data_valid_i = 1'b1;
    n = 0;
    while (data_ready_o !== 1'b1 && n < 1000) begin step(); n++; end
    ok = (data_ready_o === 1'b1);
    step();
    data_valid_i = 1'b0;
  endtask

  // Follows a frame from the first cycle after acceptance up to the tx_finish_o cycle.
  task automatic watch_frame(input int drop_tick, output int bad, output int fin_tk,
                             output int rdy_hi, output int cyc);
    int tk;
    tk = 0; bad = 0; fin_tk = -1; rdy_hi = 0; cyc = 0;
    for (int i = 0; i < 16; i++) obs_bits[i] = 1'bx;
    while (cyc < 4000) begin
      if (tx_finish_o === 1'b1) begin fin_tk = tk; break; end
      if (drop_tick >= 0 && tk >= drop_tick) tx_en_i = 1'b0;
      if (tk < exp_n * OS) begin
        if (tx_o !== exp_bits[tk / OS]) bad++;
        obs_bits[tk / OS] = tx_o;
      end else bad++;
      if (data_ready_o !== 1'b0) rdy_hi++;
      if (tick_i === 1'b1) tk++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_en_i = 1'b1; data_valid_i = 1'b0; data_i = '0;
    data_bits_i = 4'd8; parity_mode_i = 3'd0; stop_bits_i = 1'b0; tick_div = 1;
`ifdef UART_TX_BREAK_EN
    break_i = 1'b0;
`endif
    repeat (3) step();
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", data_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (tx_finish_o !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", tx_finish_o); end
    reset_n = 1'b1;
    step();
    checks++; if (data_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", data_ready_o); end
    checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_line: tx %b busy %b expected tx 1 busy 0", tx_o, busy_o); end
  endtask

  task automatic test_basic();
    bit ok; int bad, fin, rdy, cyc;
    build_exp(9'h055, 8, -1, 1);
    send(9'h055, 4'd8, 3'd0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: not accepted expected accepted"); end
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL basic_start: got %b expected 0", tx_o); end
    watch_frame(-1, bad, fin, rdy, cyc);
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_levels: %0d wrong cycles expected 0", bad); end
    checks++; if (fin != 160) begin errors++; $display("FAIL basic_ticks: got %0d expected 160", fin); end
    checks++; if (cyc != 160) begin errors++; $display("FAIL basic_latency: got %0d expected 160", cyc); end
    checks++; if (rdy != 0) begin errors++; $display("FAIL basic_ready_in_frame: got %0d expected 0", rdy); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_finish: got %b expected 1", busy_o); end
    step();
    checks++; if (tx_finish_o !== 1'b0 || data_ready_o !== 1'b0) begin errors++;
      $display("FAIL basic_after_finish: finish %b ready %b expected 0 0", tx_finish_o, data_ready_o); end
    step();
    checks++; if (data_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_rise: got %b expected 1", data_ready_o); end
  endtask

  task automatic test_parity();
    logic [DW-1:0] dv [0:4];
    logic [2:0]    pm [0:4];
    logic          ep [0:4];
    bit ok; int bad, fin, rdy, cyc;
    dv[0] = 9'h107; pm[0] = 3'd1; ep[0] = 1'b1;
    dv[1] = 9'h003; pm[1] = 3'd2; ep[1] = 1'b1;
    dv[2] = 9'h000; pm[2] = 3'd3; ep[2] = 1'b1;
    dv[3] = 9'h0FF; pm[3] = 3'd4; ep[3] = 1'b0;
    dv[4] = 9'h003; pm[4] = 3'd1; ep[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      build_exp(dv[k], 7, int'(ep[k]), 1);
      send(dv[k], 4'd7, pm[k], 1'b0, ok);
      watch_frame(-1, bad, fin, rdy, cyc);
      checks++; if (obs_bits[8] !== ep[k]) begin errors++;
        $display("FAIL parity_bit[%0d]: got %b expected %b", k, obs_bits[8], ep[k]); end
      checks++; if (bad != 0 || fin != 160) begin errors++;
        $display("FAIL parity_frame[%0d]: bad %0d ticks %0d expected bad 0 ticks 160", k, bad, fin); end
    end
  endtask

  task automatic test_nine_bits();
    bit ok; int bad, fin, rdy, cyc;
    tick_div = 3;
    build_exp(9'h1FF, 9, 1, 2);
    send(9'h1FF, 4'd9, 3'd1, 1'b1, ok);
    data_bits_i = 4'd5; parity_mode_i = 3'd0; stop_bits_i = 1'b0; data_i = '0;
    watch_frame(-1, bad, fin, rdy, cyc);
    checks++; if (bad != 0) begin errors++; $display("FAIL nine_levels: %0d wrong cycles expected 0", bad); end
    checks++; if (fin != 208) begin errors++; $display("FAIL nine_ticks: got %0d expected 208", fin); end
    checks++; if (obs_bits[10] !== 1'b1) begin errors++; $display("FAIL nine_parity: got %b expected 1", obs_bits[10]); end
    tick_div = 1;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bit ok; int bad, fin, rdy, cyc;
    build_exp(9'h0FF, 5, -1, 1);
    send(9'h0FF, 4'd5, 3'd0, 1'b0, ok);
    data_i = 9'h00A; data_bits_i = 4'd2; data_valid_i = 1'b1;
    watch_frame(-1, bad, fin, rdy, cyc);
    checks++; if (bad != 0 || fin != 112) begin errors++;
      $display("FAIL b2b_first: bad %0d ticks %0d expected bad 0 ticks 112", bad, fin); end
    checks++; if (rdy != 0) begin errors++; $display("FAIL b2b_ready_in_frame: got %0d expected 0", rdy); end
    step();
    checks++; if (data_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_f1: got %b expected 0", data_ready_o); end
    step();
    checks++; if (data_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_f2: got %b expected 1", data_ready_o); end
    step();
    data_valid_i = 1'b0;
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got %b expected 0", tx_o); end
    build_exp(9'h00A, 5, -1, 1);
    watch_frame(-1, bad, fin, rdy, cyc);
    checks++; if (bad != 0 || fin != 112) begin errors++;
      $display("FAIL b2b_second: bad %0d ticks %0d expected bad 0 ticks 112", bad, fin); end
    repeat (2) step();
  endtask

  task automatic test_enable_drop();
    bit ok; int bad, fin, rdy, cyc, rhi;
    build_exp(9'h0A5, 8, -1, 1);
    send(9'h0A5, 4'd8, 3'd0, 1'b0, ok);
    watch_frame(64, bad, fin, rdy, cyc);
    checks++; if (bad != 0 || fin != 160) begin errors++;
      $display("FAIL endrop_frame: bad %0d ticks %0d expected bad 0 ticks 160", bad, fin); end
    data_valid_i = 1'b1;
    rhi = 0;
    repeat (6) begin step(); if (data_ready_o !== 1'b0 || busy_o !== 1'b0) rhi++; end
    checks++; if (rhi != 0) begin errors++; $display("FAIL endrop_ready_after: %0d cycles ready/busy high expected 0", rhi); end
    data_valid_i = 1'b0;
    tx_en_i = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int fin_seen, low_seen;
    send(9'h007, 4'd7, 3'd2, 1'b0, ok);
    repeat (130) step();
    checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rst_parity_level: got %b expected 0", tx_o); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin errors++;
      $display("FAIL rst_async: tx %b busy %b expected tx 1 busy 0", tx_o, busy_o); end
    fin_seen = 0; low_seen = 0;
    repeat (5) begin step(); if (tx_finish_o !== 1'b0) fin_seen++; end
    reset_n = 1'b1;
    repeat (200) begin
      step();
      if (tx_finish_o !== 1'b0) fin_seen++;
      if (tx_o !== 1'b1) low_seen++;
    end
    checks++; if (fin_seen != 0) begin errors++; $display("FAIL rst_no_finish: got %0d pulses expected 0", fin_seen); end
    checks++; if (low_seen != 0) begin errors++; $display("FAIL rst_line_idle: got %0d low cycles expected 0", low_seen); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int txbad, rdybad;
    txbad = 0; rdybad = 0;
    break_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (data_ready_o !== 1'b0) rdybad++;
      step();
      if (tx_o !== 1'b0 || busy_o !== 1'b1) txbad++;
    end
    break_i = 1'b0;
    step();
    checks++; if (txbad != 0) begin errors++; $display("FAIL break_line: %0d wrong cycles expected 0", txbad); end
    checks++; if (rdybad != 0) begin errors++; $display("FAIL break_ready: %0d cycles high expected 0", rdybad); end
    checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL break_release: got %b expected 1", tx_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nine_bits();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    repeat (2) step();
    test_break();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer that replaces the fixed-format transmit controller/shifter pair in the UART transmit path. It accepts one character per valid/ready handshake and serialises it LSB-first on `tx_o`: start bit, 5..`DATA_W_MAX` data bits, optional parity (even/odd/mark/space) and 1 or 2 stop bits. Bit timing comes from the shared baud oversampling strobe. The block sits between the APB register/FIFO front end and the pad.

## Interface
Parameters:
- `DATA_W_MAX`, 9: width of `data_i`; maximum data bits per frame (legal range 5..9).
- `OVERSAMPLE`, 16: `tick_i` pulses per bit period (legal range 4..32).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `tx_en_i`  in  1  transmitter enable.
- `tick_i`  in  1  one-cycle oversampling strobe from the baud generator.
- `data_i`  in  `DATA_W_MAX`  character to send; bit 0 is sent first.
- `data_valid_i`  in  1  `data_i` is valid.
- `data_ready_o`  out  1  framer will accept a character this cycle.
- `data_bits_i`  in  4  data bits per frame. Values below 5 are treated as 5; values above `DATA_W_MAX` are treated as `DATA_W_MAX`.
- `parity_mode_i`  in  3  parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space. Values 5..7 are treated as none.
- `stop_bits_i`  in  1  stop bits: 0 = one, 1 = two.
- `tx_o`  out  1  serial line, registered, idle high.
- `busy_o`  out  1  high in any state other than IDLE.
- `tx_finish_o`  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states:
  - IDLE: `tx_o`=1; `data_ready_o` = `tx_en_i`.
    - On `data_valid_i & data_ready_o`: capture `data_i`, `data_bits_i`, `parity_mode_i` and `stop_bits_i` into shadow registers, clear the tick and bit counters, go to START.
  - START: `tx_o`=0. Go to DATA after `OVERSAMPLE` ticks.
  - DATA: `tx_o` = shift register LSB. Shift after each `OVERSAMPLE` ticks. After `data_bits` bits, go to PARITY if parity ≠ none, else go to STOP.
  - PARITY: `tx_o` = computed parity bit. Go to STOP after `OVERSAMPLE` ticks.
  - STOP: `tx_o`=1. Lasts `OVERSAMPLE` × (1 + `stop_bits`) ticks, then go to FINISH.
  - FINISH: `tx_o`=1, `tx_finish_o`=1 for exactly one cycle, then go to IDLE unconditionally.
- Parity is computed over the captured data bits [data_bits-1:0] only; higher bits are ignored.
  - even: XOR of those bits.
  - odd: inverted XOR.
  - mark: 1.
  - space: 0.
- Configuration inputs are read only at acceptance. Changing them mid-frame has no effect on the current frame.
- `tx_en_i` falling mid-frame does not truncate the frame. The frame completes normally, then `data_ready_o` stays low.
- `data_ready_o` is 0 in every state except IDLE. No character is ever dropped or overwritten.

## Timing
- Reset values: `tx_o`=1, `data_ready_o`=0, `busy_o`=0, `tx_finish_o`=0; state IDLE; all counters 0.
- Reset asserted mid-frame: `tx_o` returns high immediately (asynchronously). The frame is discarded and no `tx_finish_o` pulse occurs.
- If acceptance happens in cycle N, `tx_o` falls in cycle N+1. A `tick_i` in cycle N is not counted.
- Each bit lasts exactly `OVERSAMPLE` counted ticks. A bit ends on the cycle after the tick that brings the tick counter to `OVERSAMPLE`-1. The tick counter then wraps to 0.
- Frame length = `OVERSAMPLE` × (1 + data_bits + (parity?1:0) + (1 + stop_bits)) ticks, plus one FINISH cycle.
- `tx_finish_o` is high in the cycle after the last stop-bit tick. `data_ready_o` can rise, at the earliest, in the cycle after that.
- Counter widths: tick counter is clog2(`OVERSAMPLE`) bits; bit counter is 4 bits.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- Defined:
  - Adds input `break_i` (1 bit).
  - While in IDLE with `break_i`=1: `tx_o`=0, `busy_o`=1, `data_ready_o`=0.
  - Releasing `break_i` returns `tx_o` high in the next cycle.
  - `break_i` asserted mid-frame is ignored until the frame reaches IDLE.
- Undefined: `break_i` does not exist, and IDLE behaves as described above.

## Test plan
- `OVERSAMPLE`=16, `tick_i` held high, send 0x55 with 8 data bits, parity none, 1 stop -> `tx_o` reads 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles; `tx_finish_o` pulses 160 cycles after `tx_o` falls.
- 7 data bits, even parity, data 0x07 -> parity bit 1. Odd parity, data 0x03 -> parity bit 1. Mark parity, data 0x00 -> parity bit 1.
- 9 data bits, data 0x1FF, 2 stop bits, `tick_i` every 3rd cycle -> 13 bit periods; `tx_finish_o` pulses after 208 ticks.
- 5 data bits, data 0xFF -> exactly five 1-bits, then stop; `data_ready_o` is low for the whole frame; a second character held valid is accepted 2 cycles after the first `tx_finish_o`.
- Drop `tx_en_i` during data bit 3 -> frame completes intact and `data_ready_o` stays 0. Assert `reset_n` low during the parity bit -> `tx_o`=1 at once, no `tx_finish_o` pulse.
- With `UART_TX_BREAK_EN` defined, hold `break_i` for 40 cycles in IDLE -> `tx_o`=0 and `data_ready_o`=0 for those 40 cycles, then `tx_o`=1.
